// File: rtl/opb_reg_pkg.sv
// Shared definitions for the OPB register bank: bus widths, FSM states and
// the byte-enable merge / OPB bit-order helpers.
package opb_reg_pkg;

    localparam int OPB_AW = 32;
    localparam int OPB_DW = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        HOLD = 2'd2
    } opb_state_t;

    // be[b] qualifies little-endian byte b (bits 8b+7..8b)
    function automatic logic [31:0] be_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        end
        return r;
    endfunction

    // OPB numbers bit 0 as the MSB; user logic sees bit 31 as the MSB
    function automatic logic [31:0] opb_to_le(input logic [0:31] d);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[31-i] = d[i];
        end
        return r;
    endfunction

    function automatic logic [0:31] le_to_opb(input logic [31:0] d);
        logic [0:31] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = d[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/opb_register_bank_ppc2simulink_word.sv
// One 32-bit register with byte-enable write and an optional one-cycle
// update pulse (always on write, or only when the stored value changes).
module opb_reg_word
    import opb_reg_pkg::*;
#(
    parameter logic [31:0] P_RESET_VAL    = 32'h0000_0000,
    parameter int          P_HAS_PULSE    = 1,
    parameter int          P_PULSE_ALWAYS = 1
) (
    input  logic        i_clk,
    input  logic        i_srst,
    input  logic        i_we,
    input  logic [3:0]  i_be,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_word,
    output logic        o_update
);

    logic [31:0] r_word;
    logic        r_upd;
    logic [31:0] w_next;

    assign w_next = be_merge(r_word, i_wdata, i_be);

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_word <= P_RESET_VAL;
            r_upd  <= 1'b0;
        end else begin
            r_upd <= (P_HAS_PULSE != 0) && i_we &&
                     ((P_PULSE_ALWAYS != 0) || (w_next != r_word));
            if (i_we) begin
                r_word <= w_next;
            end
        end
    end

    assign o_word   = r_word;
    assign o_update = r_upd;

endmodule

// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave exposing C_NUM_REGS software-writable registers to fabric,
// with readback, update strobes and optional shadow/commit staging.
module opb_register_bank_ppc2simulink
    import opb_reg_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
    parameter logic [31:0] C_HIGHADDR   = 32'h0000_00FF,
    parameter int          C_OPB_AWIDTH = OPB_AW,
    parameter int          C_OPB_DWIDTH = OPB_DW,
    parameter int          C_NUM_REGS   = 4,
    parameter int          C_SHADOW     = 0,
    parameter logic [31:0] C_RESET_VAL  = 32'h0000_0000,
    parameter string       C_FAMILY     = "virtex5"
) (
    input  logic                      OPB_Clk,
    input  logic                      OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
    input  logic [0:3]                OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
    input  logic                      OPB_RNW,
    input  logic                      OPB_select,
    input  logic                      OPB_seqAddr,
    output logic [0:31]               Sl_DBus,
    output logic                      Sl_errAck,
    output logic                      Sl_retry,
    output logic                      Sl_toutSup,
    output logic                      Sl_xferAck,
    output logic [32*C_NUM_REGS-1:0]  user_data_out,
    output logic [C_NUM_REGS-1:0]     user_update
);

    opb_state_t  r_state;
    logic        r_ack;
    logic [31:0] r_dbus;
    logic [29:0] r_off;
    logic        r_rnw;

    logic        w_hit;
    logic [29:0] w_off;
    logic [31:0] w_rdata;
    logic [31:0] w_wdata;
    logic [3:0]  w_be;
    logic        w_wr;
    logic        w_commit;

    logic [31:0] w_live   [C_NUM_REGS];
    logic [31:0] w_shadow [C_NUM_REGS];
    logic [C_NUM_REGS-1:0] w_live_upd;
    logic [C_NUM_REGS-1:0] w_shadow_upd;

    assign w_hit = OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
    assign w_off = 30'((OPB_ABus - C_BASEADDR) >> 2);

    // w_shadow mirrors the live word when staging is disabled
    always_comb begin
        w_rdata = '0;
        for (int k = 0; k < C_NUM_REGS; k++) begin
            if (w_off == 30'(k)) begin
                w_rdata = w_shadow[k];
            end
        end
    end

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            r_state <= IDLE;
            r_ack   <= 1'b0;
            r_dbus  <= '0;
            r_off   <= '0;
            r_rnw   <= 1'b0;
        end else begin
            r_ack  <= 1'b0;
            r_dbus <= '0;
            case (r_state)
                IDLE: begin
                    if (w_hit) begin
                        r_state <= ACK;
                        r_ack   <= 1'b1;
                        r_off   <= w_off;
                        r_rnw   <= OPB_RNW;
                        if (OPB_RNW) begin
                            r_dbus <= w_rdata;
                        end
                    end
                end
                ACK:     r_state <= HOLD;
                HOLD:    if (!OPB_select) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Reset suppresses an ack already scheduled for the current cycle
    assign Sl_xferAck = r_ack && !OPB_Rst;
    assign Sl_DBus    = OPB_Rst ? '0 : le_to_opb(r_dbus);
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

    assign w_wdata  = opb_to_le(OPB_DBus);
    assign w_be     = {OPB_BE[0], OPB_BE[1], OPB_BE[2], OPB_BE[3]};
    assign w_wr     = (r_state == ACK) && !r_rnw;
    assign w_commit = w_wr && (r_off == 30'(C_NUM_REGS)) && (C_SHADOW != 0) && w_wdata[0];

    genvar gi;
    generate
        for (gi = 0; gi < C_NUM_REGS; gi++) begin : g_reg
            if (C_SHADOW != 0) begin : g_staged
                opb_reg_word #(
                    .P_RESET_VAL   (C_RESET_VAL),
                    .P_HAS_PULSE   (0),
                    .P_PULSE_ALWAYS(0)
                ) u_shadow (
                    .i_clk   (OPB_Clk),
                    .i_srst  (OPB_Rst),
                    .i_we    (w_wr && (r_off == 30'(gi))),
                    .i_be    (w_be),
                    .i_wdata (w_wdata),
                    .o_word  (w_shadow[gi]),
                    .o_update(w_shadow_upd[gi])
                );
                opb_reg_word #(
                    .P_RESET_VAL   (C_RESET_VAL),
                    .P_HAS_PULSE   (1),
                    .P_PULSE_ALWAYS(0)
                ) u_live (
                    .i_clk   (OPB_Clk),
                    .i_srst  (OPB_Rst),
                    .i_we    (w_commit),
                    .i_be    (4'hF),
                    .i_wdata (w_shadow[gi]),
                    .o_word  (w_live[gi]),
                    .o_update(w_live_upd[gi])
                );
            end else begin : g_direct
                opb_reg_word #(
                    .P_RESET_VAL   (C_RESET_VAL),
                    .P_HAS_PULSE   (1),
                    .P_PULSE_ALWAYS(1)
                ) u_live (
                    .i_clk   (OPB_Clk),
                    .i_srst  (OPB_Rst),
                    .i_we    (w_wr && (r_off == 30'(gi))),
                    .i_be    (w_be),
                    .i_wdata (w_wdata),
                    .o_word  (w_live[gi]),
                    .o_update(w_live_upd[gi])
                );
                assign w_shadow[gi]     = w_live[gi];
                assign w_shadow_upd[gi] = 1'b0;
            end
            assign user_data_out[32*gi +: 32] = w_live[gi];
        end
    endgenerate

    // Shadow words never pulse, so this is effectively the live strobes
    assign user_update = w_live_upd | w_shadow_upd;

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Drives a direct-mode and a shadow-mode register bank from one OPB master
// and compares every transfer against an array-based reference model.
module tb_opb_register_bank_ppc2simulink;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam logic [31:0] HIGH = 32'h0000_10FF;
    localparam logic [31:0] RSTV = 32'hDEAD_BEEF;
    localparam int          NR   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [0:31] abus;
    logic [0:3]  be;
    logic [0:31] dbus_in;
    logic        rnw;
    logic [1:0]  sel;
    logic        seq_addr;

    logic [0:31]       sdbus0, sdbus1;
    logic              err0, err1, rty0, rty1, tout0, tout1, ack0, ack1;
    logic [32*NR-1:0]  udo0, udo1;
    logic [NR-1:0]     upd0, upd1;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_live   [2][NR];
    logic [31:0] m_shadow [2][NR];

    always #5 clk = ~clk;

    opb_register_bank_ppc2simulink #(
        .C_BASEADDR(BASE), .C_HIGHADDR(HIGH), .C_NUM_REGS(NR),
        .C_SHADOW(0), .C_RESET_VAL(RSTV)
    ) u_dut0 (
        .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be),
        .OPB_DBus(dbus_in), .OPB_RNW(rnw), .OPB_select(sel[0]),
        .OPB_seqAddr(seq_addr), .Sl_DBus(sdbus0), .Sl_errAck(err0),
        .Sl_retry(rty0), .Sl_toutSup(tout0), .Sl_xferAck(ack0),
        .user_data_out(udo0), .user_update(upd0)
    );

    opb_register_bank_ppc2simulink #(
        .C_BASEADDR(BASE), .C_HIGHADDR(HIGH), .C_NUM_REGS(NR),
        .C_SHADOW(1), .C_RESET_VAL(RSTV)
    ) u_dut1 (
        .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be),
        .OPB_DBus(dbus_in), .OPB_RNW(rnw), .OPB_select(sel[1]),
        .OPB_seqAddr(seq_addr), .Sl_DBus(sdbus1), .Sl_errAck(err1),
        .Sl_retry(rty1), .Sl_toutSup(tout1), .Sl_xferAck(ack1),
        .user_data_out(udo1), .user_update(upd1)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] model_udo(input int d);
        return {m_live[d][3], m_live[d][2], m_live[d][1], m_live[d][0]};
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < NR; k++) begin
                m_live[d][k]   = RSTV;
                m_shadow[d][k] = RSTV;
            end
    endtask

    // be_le[b] enables little-endian byte b; OPB BE[0] is be_le[3]
    task automatic do_xfer(input int d, input bit rd, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] be_le, input int hold);
        bit          in_win;
        int          off;
        logic [31:0] exp_rd;
        logic [3:0]  exp_pulse;
        int          nack;
        int          ack_cyc;
        logic [31:0] rdv;
        bit          stray;
        logic [3:0]  upd_c2, upd_other, upd_now;
        logic        a;
        logic [31:0] db;

        in_win    = (addr >= BASE) && (addr <= HIGH);
        off       = int'((addr - BASE) >> 2);
        exp_rd    = '0;
        exp_pulse = '0;
        if (in_win) begin
            if (rd) begin
                if (off < NR) exp_rd = (d == 1) ? m_shadow[d][off] : m_live[d][off];
            end else if (off < NR) begin
                for (int b = 0; b < 4; b++) begin
                    if (be_le[b]) begin
                        if (d == 0) m_live[d][off][8*b +: 8]   = data[8*b +: 8];
                        else        m_shadow[d][off][8*b +: 8] = data[8*b +: 8];
                    end
                end
                if (d == 0) exp_pulse = 4'(1 << off);
            end else if (off == NR && d == 1 && data[0]) begin
                for (int k = 0; k < NR; k++) begin
                    if (m_live[d][k] != m_shadow[d][k]) exp_pulse[k] = 1'b1;
                    m_live[d][k] = m_shadow[d][k];
                end
            end
        end

        @(negedge clk);
        abus = addr; dbus_in = data; be = be_le; rnw = rd; sel[d] = 1'b1;
        nack = 0; ack_cyc = 0; rdv = '0; stray = 0; upd_c2 = '0; upd_other = '0;
        for (int c = 1; c <= hold + 1; c++) begin
            @(posedge clk); #1;
            a       = d ? ack1 : ack0;
            db      = d ? sdbus1 : sdbus0;
            upd_now = d ? upd1 : upd0;
            if (a) begin
                nack++;
                ack_cyc = c;
                rdv     = db;
            end else if (db != 0) begin
                stray = 1;
            end
            if (c == 2) upd_c2 = upd_now;
            else        upd_other |= upd_now;
            if (c == hold) begin
                @(negedge clk);
                sel[d] = 1'b0;
            end
        end

        $display("xfer dut=%0d %s addr=%h data=%h be=%b hold=%0d acks=%0d rd=%h upd=%b",
                 d, rd ? "RD" : "WR", addr, data, be_le, hold, nack, rdv, upd_c2);
        chk("ack_count", nack, in_win ? 1 : 0);
        if (in_win) begin
            chk("ack_cycle", ack_cyc, 1);
            chk("rdata", rdv, exp_rd);
        end
        chk("dbus_outside_ack", stray, 0);
        chk("update_pulse", upd_c2, exp_pulse);
        chk("update_extra", upd_other, 0);
        chk("user_data_out", d ? udo1 : udo0, model_udo(d));
        chk("tied_outputs", {err0, rty0, tout0, err1, rty1, tout1}, 0);
    endtask

    initial begin
        rst = 1'b1; sel = '0; abus = '0; be = '0; dbus_in = '0; rnw = 1'b0; seq_addr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        #1;
        chk("reset_ack", {ack0, ack1}, 0);
        chk("reset_dbus", {sdbus0, sdbus1}, 0);
        chk("reset_udo0", udo0, model_udo(0));
        chk("reset_udo1", udo1, model_udo(1));
        chk("reset_upd", {upd0, upd1}, 0);

        for (int d = 0; d < 2; d++)
            for (int k = 0; k <= NR; k++)
                do_xfer(d, 1, BASE + 32'(4*k), 32'h0, 4'hF, 2);

        do_xfer(0, 0, BASE + 32'd8, 32'h1234_5678, 4'b1111, 2);
        do_xfer(0, 0, BASE + 32'd8, 32'hAAAA_AAAA, 4'b0101, 2);
        chk("be_merge_reg2", udo0[95:64], 32'h12AA_56AA);

        do_xfer(1, 0, BASE + 32'd0, 32'h0000_0001, 4'hF, 2);
        do_xfer(1, 0, BASE + 32'd4, 32'h0000_0002, 4'hF, 3);
        do_xfer(1, 1, BASE + 32'd0, 32'h0, 4'hF, 2);
        do_xfer(1, 0, BASE + 32'd16, 32'h0000_0000, 4'hF, 2);
        do_xfer(1, 0, BASE + 32'd16, 32'h0000_0001, 4'hF, 2);
        chk("commit_live01", udo1[63:0], 64'h0000_0002_0000_0001);

        do_xfer(0, 1, BASE + 32'd8, 32'h0, 4'hF, 6);
        do_xfer(0, 0, BASE + 32'd4, 32'hCAFE_F00D, 4'hF, 6);

        do_xfer(0, 1, BASE + 32'd28, 32'h0, 4'hF, 2);
        do_xfer(1, 0, BASE + 32'd28, 32'hFFFF_FFFF, 4'hF, 2);
        do_xfer(0, 0, 32'h0000_2000, 32'h5555_5555, 4'hF, 3);
        do_xfer(1, 1, 32'h0000_0FFC, 32'h0, 4'hF, 3);

        // reset lands in the ACK cycle of a write
        @(negedge clk);
        abus = BASE + 32'd4; dbus_in = 32'h1111_2222; be = 4'hF; rnw = 1'b0; sel[0] = 1'b1;
        @(posedge clk);
        rst = 1'b1;
        #1;
        chk("rst_in_ack_noack", ack0, 0);
        @(posedge clk); #1;
        model_reset();
        chk("rst_in_ack_noack2", ack0, 0);
        chk("rst_in_ack_udo", udo0, model_udo(0));
        chk("rst_in_ack_upd", upd0, 0);
        @(negedge clk);
        rst = 1'b0; sel[0] = 1'b0;
        do_xfer(0, 1, BASE + 32'd4, 32'h0, 4'hF, 2);

        for (int t = 0; t < 40; t++) begin
            int          d, off, hold;
            bit          rd;
            logic [31:0] addr, data;
            d    = int'($urandom_range(0, 1));
            rd   = 1'($urandom_range(0, 2) == 0);
            off  = int'($urandom_range(0, 7));
            addr = BASE + 32'(4*off) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) addr = HIGH + 32'd1 + 32'($urandom_range(0, 255));
            data = $urandom;
            hold = int'($urandom_range(2, 4));
            do_xfer(d, rd, addr, data, 4'($urandom_range(0, 15)), hold);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/opb_register_bank_ppc2simulink.md
Name: opb_register_bank_ppc2simulink

Overview:
Parametrised successor to the single software-to-fabric OPB register. It provides C_NUM_REGS 32-bit PPC-writable control registers behind one OPB slave, with byte-enable writes, readback, per-register update strobes and an optional shadow/commit mode. Shadow/commit mode lets software update a multi-register setting atomically. It sits on the OPB bus beside other Simulink yellow-block slaves, and drives user logic in the same clock domain.

Parameters:
C_BASEADDR, 32'h00000000, first byte address of the slave window
C_HIGHADDR, 32'h000000FF, last byte address of the slave window; window must cover (C_NUM_REGS+1)*4 bytes
C_OPB_AWIDTH, 32, OPB address width
C_OPB_DWIDTH, 32, OPB data width; only 32 is supported
C_NUM_REGS, 4, number of user registers, 1..32
C_SHADOW, 0, 0 = writes go straight to user outputs; 1 = writes go to shadow regs, applied on commit
C_RESET_VAL, 32'h00000000, reset value of every register (shadow and live)
C_FAMILY, "virtex5", target family, informational

Ports:
OPB_Clk  in  1  single clock for bus and user side
OPB_Rst  in  1  synchronous active-high reset
OPB_ABus  in  [0:31]  byte address, bit 0 = MSB
OPB_BE  in  [0:3]  byte enables; BE[0] qualifies DBus[0:7]
OPB_DBus  in  [0:31]  write data
OPB_RNW  in  1  1 = read, 0 = write
OPB_select  in  1  transfer request
OPB_seqAddr  in  1  ignored
Sl_DBus  out  [0:31]  read data; zero except during the read ack cycle
Sl_errAck  out  1  tied 0
Sl_retry  out  1  tied 0
Sl_toutSup  out  1  tied 0
Sl_xferAck  out  1  one-cycle transfer acknowledge
user_data_out  out  [32*C_NUM_REGS-1:0]  live registers; reg k occupies bits [32k+31:32k], OPB bit 0 maps to bit 31
user_update  out  [C_NUM_REGS-1:0]  one-cycle pulse in the cycle after reg k's live value is written

Behaviour:
- Hit: OPB_select=1 and C_BASEADDR <= OPB_ABus <= C_HIGHADDR. Word offset = (OPB_ABus - C_BASEADDR)>>2; byte-offset bits are ignored.
- FSM states:
  - IDLE: on a hit, go to ACK.
  - ACK: Sl_xferAck=1 for exactly this cycle; the write is performed or the read data is driven; go to HOLD.
  - HOLD: stay while OPB_select=1; go to IDLE when it drops. This prevents a double-ack on a lingering select.
- Latency: the ack is asserted in the 2nd cycle of select.
- Write, offset k < C_NUM_REGS: each byte with BE set is updated; the other bytes are held.
  - C_SHADOW=0: live reg k updates at the ACK edge; user_update[k] pulses the next cycle.
  - C_SHADOW=1: only shadow k updates; there is no pulse.
- Write, offset C_NUM_REGS (commit):
  - C_SHADOW=1 and DBus[31]=1 (LSB): all live regs load from shadow at once; user_update pulses for every register whose value changed; unchanged registers do not pulse.
  - C_SHADOW=0, or DBus[31]=0: no effect.
- Read, offset k < C_NUM_REGS: returns shadow k if C_SHADOW=1, live k otherwise. The commit offset reads 0.
- Offset > C_NUM_REGS inside the window: write ignored, read returns 0, normal ack, no error.
- Reset (OPB_Rst=1 at a clock edge, any state, including mid-transfer):
  - FSM -> IDLE; Sl_xferAck=0; Sl_DBus=0.
  - All shadow and live regs = C_RESET_VAL; user_update=0.
  - A transfer interrupted by reset is not acked; it will be re-issued by the master's timeout.
- The error, retry and timeout-suppress outputs are constant 0 in all states.

Decomposition:
- Shared package opb_reg_pkg: OPB width constants; FSM state typedef {IDLE, ACK, HOLD}; a function for the byte-enable merge and one for the OPB-to-little-endian bit reversal.
- One natural sub-module, opb_reg_word: a single 32-bit register with byte-enable merge and an update-pulse flop. Instantiated C_NUM_REGS times, twice when C_SHADOW=1.

Test Plan:
- Reset, then read all offsets (C_NUM_REGS=4, C_RESET_VAL=32'hDEADBEEF) -> Sl_DBus=DEADBEEF on each ack for offsets 0..3; commit offset 4 reads 0; Sl_xferAck is high exactly 1 cycle per transfer.
- C_SHADOW=0: write 32'h12345678 to offset 2 with BE=4'b1111; then write 32'hAAAAAAAA with BE=4'b0101 -> user_data_out[95:64]=12AA56AA; user_update=4'b0100 pulses twice, each 1 cycle after its ack.
- C_SHADOW=1: write offset 0 = 1 and offset 1 = 2 -> user_data_out unchanged and no pulses. Then commit with DBus[31]=1 -> both live regs update in the same cycle; user_update=4'b0011 for one cycle. Readback shows shadow values before the commit.
- select held for 6 cycles on a single transfer -> exactly one ack, in cycle 2; the next transfer is accepted only after select deasserts.
- Read of offset 7, and a select with an address outside the window -> offset 7 acks with data 0; the out-of-window access gets no ack, and no register changes in either case.
- OPB_Rst asserted in the ACK cycle of a write -> no ack is issued, the register holds C_RESET_VAL, and the FSM is in IDLE on the next cycle.
